// File: rtl/servant_wb_arbiter_if.sv
// Bus bundle for servant_wb_arbiter: NM Wishbone-classic masters on one side, one slave port on the other.
// The "master" modport is the arbiter's view; the "slave" modport is the surrounding SoC/bench view.
interface servant_wb_arbiter_if #(
    parameter int unsigned NM = 3
);
    logic [NM*32-1:0] i_m_adr;
    logic [NM*32-1:0] i_m_dat;
    logic [NM*4-1:0]  i_m_sel;
    logic [NM-1:0]    i_m_we;
    logic [NM-1:0]    i_m_cyc;
    logic [31:0]      o_m_rdt;
    logic [NM-1:0]    o_m_ack;
    logic [31:0]      o_s_adr;
    logic [31:0]      o_s_dat;
    logic [3:0]       o_s_sel;
    logic             o_s_we;
    logic             o_s_cyc;
    logic [31:0]      i_s_rdt;
    logic             i_s_ack;
    logic [NM-1:0]    o_grant;
    logic             o_timeout;

    modport master (
        input  i_m_adr, i_m_dat, i_m_sel, i_m_we, i_m_cyc, i_s_rdt, i_s_ack,
        output o_m_rdt, o_m_ack, o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc,
        output o_grant, o_timeout
    );

    modport slave (
        output i_m_adr, i_m_dat, i_m_sel, i_m_we, i_m_cyc, i_s_rdt, i_s_ack,
        input  o_m_rdt, o_m_ack, o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc,
        input  o_grant, o_timeout
    );
endinterface

// File: rtl/servant_wb_arbiter.sv
// Round-robin Wishbone-classic arbiter sharing one slave port between NM masters.
// Optional hung-slave timeout enabled by defining SERVANT_ARB_TIMEOUT_EN.
module servant_wb_arbiter #(
    parameter int unsigned NM      = 3,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                   wb_clk,
    input logic                   wb_rst,
    servant_wb_arbiter_if.master  bus
);
    localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;

    if (NM < 2 || NM > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("servant_wb_arbiter: NM or TIMEOUT out of range");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [NM-1:0] grant, grant_nxt;
    logic [IW-1:0] last, last_nxt;
    logic [IW-1:0] idx, idx_nxt;   // selected master; retained through IDLE for the slave mux
    logic          found;
    logic [IW-1:0] cidx;
    int unsigned   c;
`ifdef SERVANT_ARB_TIMEOUT_EN
    logic [15:0]   cnt, cnt_nxt;
`endif

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state <= IDLE;
            grant <= '0;
            last  <= IW'(NM - 1);
            idx   <= '0;
`ifdef SERVANT_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
            idx   <= idx_nxt;
`ifdef SERVANT_ARB_TIMEOUT_EN
            cnt   <= cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        last_nxt      = last;
        idx_nxt       = idx;
        found         = 1'b0;
        cidx          = '0;
        c             = 0;
        bus.o_m_ack   = '0;
        bus.o_s_cyc   = 1'b0;
        bus.o_m_rdt   = bus.i_s_rdt;
        bus.o_timeout = 1'b0;
`ifdef SERVANT_ARB_TIMEOUT_EN
        cnt_nxt       = cnt;
`endif
        case (state)
            IDLE: begin
                // Scan starting just after the last served master so every requester waits at most NM-1 turns.
                for (int unsigned i = 1; i <= NM; i++) begin
                    c    = (32'(last) + i) % NM;
                    cidx = IW'(c);
                    if (!found && bus.i_m_cyc[cidx]) begin
                        found            = 1'b1;
                        idx_nxt          = cidx;
                        grant_nxt        = '0;
                        grant_nxt[cidx]  = 1'b1;
                        state_nxt        = BUSY;
                    end
                end
`ifdef SERVANT_ARB_TIMEOUT_EN
                cnt_nxt = '0;
`endif
            end
            BUSY: begin
                bus.o_s_cyc = bus.i_m_cyc[idx];
                if (bus.i_s_ack) begin
                    bus.o_m_ack[idx] = 1'b1;
                    state_nxt        = IDLE;
                end else if (!bus.i_m_cyc[idx]) begin
                    state_nxt        = IDLE;
`ifdef SERVANT_ARB_TIMEOUT_EN
                end else if (cnt == 16'(TIMEOUT - 1)) begin
                    bus.o_m_ack[idx] = 1'b1;
                    bus.o_m_rdt      = '0;
                    bus.o_timeout    = 1'b1;
                    state_nxt        = IDLE;
                end else begin
                    cnt_nxt          = cnt + 16'd1;
`endif
                end
                if (state_nxt == IDLE) begin
                    last_nxt  = idx;
                    grant_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.o_s_adr = '0;
        bus.o_s_dat = '0;
        bus.o_s_sel = '0;
        bus.o_s_we  = 1'b0;
        for (int unsigned k = 0; k < NM; k++) begin
            if (IW'(k) == idx) begin
                bus.o_s_adr = bus.i_m_adr[k*32 +: 32];
                bus.o_s_dat = bus.i_m_dat[k*32 +: 32];
                bus.o_s_sel = bus.i_m_sel[k*4 +: 4];
                bus.o_s_we  = bus.i_m_we[k];
            end
        end
    end

    assign bus.o_grant = grant;
endmodule
